// File: rtl/tcs_cmp_vector_gen.sv
// tcs_cmp_vector_gen
// Stimulus and golden-result generator for an N-bit two's-complement
// comparator. A run emits every ordered operand pair (SWEEP), followed by
// the equal-operand diagonal (DIAG). Each vector carries the expected EQ and
// GT results. Vectors are offered over a valid/ready handshake, and every
// output is registered.
module tcs_cmp_vector_gen #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           ready,
  output logic           valid,
  output logic [N-1:0]   vec_a,
  output logic [N-1:0]   vec_b,
  output logic           exp_eq,
  output logic           exp_gt,
  output logic           done,
  output logic [2*N:0]   vec_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DIAG  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2*N-1:0] IDX_ONE   = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] IDX_LAST  = '1;
  localparam logic [N-1:0]   DIAG_LAST = '1;
  localparam logic [2*N:0]   CNT_ONE   = {{(2*N){1'b0}}, 1'b1};

  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] idx_q, idx_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   vec_a_q, vec_a_d;
  logic [N-1:0]   vec_b_q, vec_b_d;
  logic           eq_q, eq_d;
  logic           gt_q, gt_d;
  logic           done_q, done_d;
  logic [2*N:0]   cnt_q, cnt_d;

  logic           xfer;
  logic [2*N-1:0] idx_inc;
  logic           load;
  logic           finish;
  logic [N-1:0]   next_a;
  logic [N-1:0]   next_b;

  // Sequencing: decide the next state, index and count, and which operand
  // pair (if any) to present next.
  always_comb begin
    xfer    = valid_q && ready;
    idx_inc = idx_q + IDX_ONE;
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    finish  = 1'b0;
    next_a  = '0;
    next_b  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          valid_d = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      S_SWEEP: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_ONE;
          load  = 1'b1;
          // The last pair hands over to DIAG j=0 as a state change; the index
          // restarts rather than overflowing into the operand fields.
          if (idx_q == IDX_LAST) begin
            state_d = S_DIAG;
            idx_d   = '0;
          end else begin
            idx_d  = idx_inc;
            next_a = idx_inc[2*N-1:N];
            next_b = idx_inc[N-1:0];
          end
        end
      end
      S_DIAG: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_ONE;
          if (idx_q[N-1:0] == DIAG_LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            finish  = 1'b1;
          end else begin
            idx_d  = idx_inc;
            next_a = idx_inc[N-1:0];
            next_b = idx_inc[N-1:0];
            load   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Vector register inputs: load a fresh pair with its expected results,
  // clear on completion, otherwise hold bit-stable.
  always_comb begin
    vec_a_d = vec_a_q;
    vec_b_d = vec_b_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    if (finish) begin
      vec_a_d = '0;
      vec_b_d = '0;
      eq_d    = 1'b0;
      gt_d    = 1'b0;
    end else if (load) begin
      vec_a_d = next_a;
      vec_b_d = next_b;
      eq_d    = (next_a == next_b);
      gt_d    = ($signed(next_a) > $signed(next_b));
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      vec_a_q <= '0;
      vec_b_q <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      vec_a_q <= vec_a_d;
      vec_b_q <= vec_b_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid     = valid_q;
  assign vec_a     = vec_a_q;
  assign vec_b     = vec_b_q;
  assign exp_eq    = eq_q;
  assign exp_gt    = gt_q;
  assign done      = done_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_tcs_cmp_vector_gen.sv
// Testbench for tcs_cmp_vector_gen: an N=8 instance for the directed
// scenarios and the full-length run, and an N=4 instance for a complete run
// under random backpressure.
module tb_tcs_cmp_vector_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, ready8;
  logic        valid8, eq8, gt8, done8;
  logic [7:0]  a8, b8;
  logic [16:0] cnt8;

  logic        rst4, start4, ready4;
  logic        valid4, eq4, gt4, done4;
  logic [3:0]  a4, b4;
  logic [8:0]  cnt4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned k8 = 0;

  tcs_cmp_vector_gen #(.N(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .ready(ready8),
    .valid(valid8), .vec_a(a8), .vec_b(b8), .exp_eq(eq8), .exp_gt(gt8),
    .done(done8), .vec_count(cnt8)
  );

  tcs_cmp_vector_gen #(.N(4)) dut4 (
    .clk(clk), .reset(rst4), .start(start4), .ready(ready4),
    .valid(valid4), .vec_a(a4), .vec_b(b4), .exp_eq(eq4), .exp_gt(gt4),
    .done(done4), .vec_count(cnt4)
  );

  // Reference: k-th vector of an 8-bit run, results from signed integers.
  function automatic void ref8(input int unsigned k, output logic [7:0] a,
                               output logic [7:0] b, output logic eq,
                               output logic gt);
    int ia, ib;
    if (k < 65536) begin
      a = 8'(k / 256);
      b = 8'(k % 256);
    end else begin
      a = 8'(k - 65536);
      b = a;
    end
    ia = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    ib = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    eq = (ia == ib);
    gt = (ia > ib);
  endfunction

  // Reference: k-th vector of a 4-bit run.
  function automatic void ref4(input int unsigned k, output logic [3:0] a,
                               output logic [3:0] b, output logic eq,
                               output logic gt);
    int ia, ib;
    if (k < 256) begin
      a = 4'(k / 16);
      b = 4'(k % 16);
    end else begin
      a = 4'(k - 256);
      b = a;
    end
    ia = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    ib = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    eq = (ia == ib);
    gt = (ia > ib);
  endfunction

  task automatic test_reset();
    rst8 = 1'b1; start8 = 1'b0; ready8 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; ready4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    rst4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({valid8, done8, cnt8, a8, b8, eq8, gt8} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: got v=%b d=%b cnt=%h a=%h b=%h eq=%b gt=%b, expected all 0",
                 i, valid8, done8, cnt8, a8, b8, eq8, gt8);
      end
    end
  endtask

  task automatic test_sweep_order();
    logic [7:0] ea, eb;
    logic eeq, egt;
    bit stop;
    int unsigned cyc;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k8 = 0;
    checks++;
    if ({valid8, a8, b8, eq8, gt8, cnt8} !== {1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 17'd0}) begin
      errors++;
      $display("FAIL start_latency: got v=%b a=%h b=%h eq=%b gt=%b cnt=%h, expected v=1 a=00 b=00 eq=1 gt=0 cnt=0",
               valid8, a8, b8, eq8, gt8, cnt8);
    end
    ready8 = 1'b1;
    stop = 1'b0;
    cyc = 0;
    while (k8 < 32'h8100 && !stop && cyc < 40000) begin
      ref8(k8, ea, eb, eeq, egt);
      checks++;
      if ({valid8, a8, b8, eq8, gt8, done8, cnt8} !== {1'b1, ea, eb, eeq, egt, 1'b0, 17'(k8)}) begin
        errors++; stop = 1'b1;
        $display("FAIL sweep k=%0d: got v=%b a=%h b=%h eq=%b gt=%b d=%b cnt=%h, expected v=1 a=%h b=%h eq=%b gt=%b d=0 cnt=%h",
                 k8, valid8, a8, b8, eq8, gt8, done8, cnt8, ea, eb, eeq, egt, 17'(k8));
      end
      if (k8 == 1) begin
        checks++;
        if ({a8, b8, eq8, gt8} !== {8'h00, 8'h01, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL second_vec: got a=%h b=%h eq=%b gt=%b, expected a=00 b=01 eq=0 gt=0", a8, b8, eq8, gt8);
        end
      end
      if (k8 == 32'h0080) begin
        checks++;
        if ({a8, b8, gt8} !== {8'h00, 8'h80, 1'b1}) begin
          errors++;
          $display("FAIL idx_0080: got a=%h b=%h gt=%b, expected a=00 b=80 gt=1", a8, b8, gt8);
        end
      end
      if (k8 == 32'h7F80) begin
        checks++;
        if ({a8, b8, gt8} !== {8'h7F, 8'h80, 1'b1}) begin
          errors++;
          $display("FAIL idx_7f80: got a=%h b=%h gt=%b, expected a=7f b=80 gt=1", a8, b8, gt8);
        end
      end
      if (k8 == 32'h807F) begin
        checks++;
        if ({a8, b8, gt8} !== {8'h80, 8'h7F, 1'b0}) begin
          errors++;
          $display("FAIL idx_807f: got a=%h b=%h gt=%b, expected a=80 b=7f gt=0", a8, b8, gt8);
        end
      end
      if (ready8) k8++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (k8 != 32'h8100) begin
      errors++;
      $display("FAIL sweep_progress: reached k=%0d, expected %0d", k8, 32'h8100);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ea, eb;
    logic eeq, egt;
    ready8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ref8(k8, ea, eb, eeq, egt);
      checks++;
      if ({valid8, a8, b8, eq8, gt8, cnt8} !== {1'b1, ea, eb, eeq, egt, 17'(k8)}) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d: got v=%b a=%h b=%h eq=%b gt=%b cnt=%h, expected v=1 a=%h b=%h eq=%b gt=%b cnt=%h",
                 i, valid8, a8, b8, eq8, gt8, cnt8, ea, eb, eeq, egt, 17'(k8));
      end
      if (i < 5) @(negedge clk);
    end
    ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ref8(k8, ea, eb, eeq, egt);
      checks++;
      if ({valid8, a8, b8, eq8, gt8, cnt8} !== {1'b1, ea, eb, eeq, egt, 17'(k8)}) begin
        errors++;
        $display("FAIL backpressure_resume k=%0d: got v=%b a=%h b=%h cnt=%h, expected v=1 a=%h b=%h cnt=%h",
                 k8, valid8, a8, b8, cnt8, ea, eb, 17'(k8));
      end
      k8++;
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] ea, eb;
    logic eeq, egt;
    ready8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start8 = (i == 1 || i == 2);
      ref8(k8, ea, eb, eeq, egt);
      checks++;
      if ({valid8, a8, b8, eq8, gt8, cnt8} !== {1'b1, ea, eb, eeq, egt, 17'(k8)}) begin
        errors++;
        $display("FAIL start_in_sweep k=%0d: got v=%b a=%h b=%h cnt=%h, expected v=1 a=%h b=%h cnt=%h",
                 k8, valid8, a8, b8, cnt8, ea, eb, 17'(k8));
      end
      k8++;
      @(negedge clk);
    end
    start8 = 1'b0;
  endtask

  task automatic test_completion();
    logic [7:0] ea, eb;
    logic eeq, egt;
    bit stop;
    int unsigned cyc;
    ready8 = 1'b1;
    stop = 1'b0;
    cyc = 0;
    while (k8 < 65792 && !stop && cyc < 40000) begin
      start8 = (k8 == 65600);
      ref8(k8, ea, eb, eeq, egt);
      checks++;
      if ({valid8, a8, b8, eq8, gt8, done8, cnt8} !== {1'b1, ea, eb, eeq, egt, 1'b0, 17'(k8)}) begin
        errors++; stop = 1'b1;
        $display("FAIL stream k=%0d: got v=%b a=%h b=%h eq=%b gt=%b d=%b cnt=%h, expected v=1 a=%h b=%h eq=%b gt=%b d=0 cnt=%h",
                 k8, valid8, a8, b8, eq8, gt8, done8, cnt8, ea, eb, eeq, egt, 17'(k8));
      end
      if (k8 == 65535 || k8 == 65791) begin
        checks++;
        if ({a8, b8, eq8, gt8} !== {8'hFF, 8'hFF, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL last_ff k=%0d: got a=%h b=%h eq=%b gt=%b, expected a=ff b=ff eq=1 gt=0", k8, a8, b8, eq8, gt8);
        end
      end
      if (k8 == 65536) begin
        checks++;
        if ({a8, b8, eq8} !== {8'h00, 8'h00, 1'b1}) begin
          errors++;
          $display("FAIL diag_start: got a=%h b=%h eq=%b, expected a=00 b=00 eq=1", a8, b8, eq8);
        end
      end
      k8++;
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    checks++;
    if (k8 != 65792) begin
      errors++;
      $display("FAIL transfer_total: reached %0d, expected 65792", k8);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({valid8, done8, cnt8} !== {1'b0, 1'b1, 17'h10100}) begin
        errors++;
        $display("FAIL done_state cyc=%0d: got v=%b d=%b cnt=%h, expected v=0 d=1 cnt=10100", i, valid8, done8, cnt8);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_restart();
    logic [7:0] ea, eb;
    logic eeq, egt;
    ready8 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if ({done8, cnt8, valid8, a8, b8, eq8, gt8} !== {1'b0, 17'd0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart: got d=%b cnt=%h v=%b a=%h b=%h eq=%b gt=%b, expected d=0 cnt=0 v=1 a=00 b=00 eq=1 gt=0",
               done8, cnt8, valid8, a8, b8, eq8, gt8);
    end
    k8 = 0;
    for (int i = 0; i < 10; i++) begin
      ref8(k8, ea, eb, eeq, egt);
      checks++;
      if ({valid8, a8, b8, eq8, gt8, cnt8} !== {1'b1, ea, eb, eeq, egt, 17'(k8)}) begin
        errors++;
        $display("FAIL restart_stream k=%0d: got v=%b a=%h b=%h cnt=%h, expected v=1 a=%h b=%h cnt=%h",
                 k8, valid8, a8, b8, cnt8, ea, eb, 17'(k8));
      end
      k8++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] ea, eb;
    logic eeq, egt;
    bit stop;
    int unsigned cyc;
    stop = 1'b0;
    cyc = 0;
    while (k8 < 1000 && !stop && cyc < 5000) begin
      ready8 = 1'($urandom_range(0, 1));
      ref8(k8, ea, eb, eeq, egt);
      checks++;
      if ({valid8, a8, b8, eq8, gt8, cnt8} !== {1'b1, ea, eb, eeq, egt, 17'(k8)}) begin
        errors++; stop = 1'b1;
        $display("FAIL random_ready k=%0d: got v=%b a=%h b=%h eq=%b gt=%b cnt=%h, expected v=1 a=%h b=%h eq=%b gt=%b cnt=%h",
                 k8, valid8, a8, b8, eq8, gt8, cnt8, ea, eb, eeq, egt, 17'(k8));
      end
      if (ready8) k8++;
      @(negedge clk);
      cyc++;
    end
    ready8 = 1'b0;
    checks++;
    if ({valid8, cnt8} !== {1'b1, 17'd1000}) begin
      errors++;
      $display("FAIL pending_before_reset: got v=%b cnt=%0d, expected v=1 cnt=1000", valid8, cnt8);
    end
    rst8 = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid8, done8, cnt8, a8, b8, eq8, gt8} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%b cnt=%h a=%h b=%h eq=%b gt=%b, expected all 0",
               valid8, done8, cnt8, a8, b8, eq8, gt8);
    end
    start8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    start8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({valid8, done8, cnt8} !== '0) begin
        errors++;
        $display("FAIL reset_beats_start cyc=%0d: got v=%b d=%b cnt=%h, expected v=0 d=0 cnt=0", i, valid8, done8, cnt8);
      end
      @(negedge clk);
    end
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ready8 = 1'b1;
    k8 = 0;
    for (int i = 0; i < 3; i++) begin
      ref8(k8, ea, eb, eeq, egt);
      checks++;
      if ({valid8, a8, b8, eq8, gt8, cnt8} !== {1'b1, ea, eb, eeq, egt, 17'(k8)}) begin
        errors++;
        $display("FAIL after_reset_start k=%0d: got v=%b a=%h b=%h cnt=%h, expected v=1 a=%h b=%h cnt=%h",
                 k8, valid8, a8, b8, cnt8, ea, eb, 17'(k8));
      end
      k8++;
      @(negedge clk);
    end
  endtask

  task automatic test_random_full_n4();
    logic [3:0] ea, eb;
    logic eeq, egt;
    int unsigned k4;
    bit stop;
    int unsigned cyc;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k4 = 0;
    stop = 1'b0;
    cyc = 0;
    while (k4 < 272 && !stop && cyc < 3000) begin
      ready4 = 1'($urandom_range(0, 1));
      ref4(k4, ea, eb, eeq, egt);
      checks++;
      if ({valid4, a4, b4, eq4, gt4, done4, cnt4} !== {1'b1, ea, eb, eeq, egt, 1'b0, 9'(k4)}) begin
        errors++; stop = 1'b1;
        $display("FAIL n4_stream k=%0d: got v=%b a=%h b=%h eq=%b gt=%b d=%b cnt=%h, expected v=1 a=%h b=%h eq=%b gt=%b d=0 cnt=%h",
                 k4, valid4, a4, b4, eq4, gt4, done4, cnt4, ea, eb, eeq, egt, 9'(k4));
      end
      if (ready4) k4++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (k4 != 272) begin
      errors++;
      $display("FAIL n4_total: reached %0d transfers, expected 272", k4);
    end
    checks++;
    if ({valid4, done4, cnt4} !== {1'b0, 1'b1, 9'h110}) begin
      errors++;
      $display("FAIL n4_done: got v=%b d=%b cnt=%h, expected v=0 d=1 cnt=110", valid4, done4, cnt4);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep_order();
    test_backpressure();
    test_start_ignored();
    test_completion();
    test_restart();
    test_reset_mid_run();
    test_random_full_n4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
